// File: rtl/freq_gate_ctrl.sv
// Frequency meter sequencer: counts synchronized rising edges of sig_in over a fixed gate
// window and publishes the saturated result with a one-cycle valid pulse.
`timescale 1ns/1ps
module freq_gate_ctrl #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DISP_MAX    = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_in,
    input  logic        enable,
    output logic [31:0] counter,
    output logic        valid,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned TimerW = $clog2(GATE_CYCLES);
    // Compare width wide enough for both the edge count and DISP_MAX.
    localparam int unsigned CmpW = (CNT_W > 32) ? CNT_W : 32;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StGate, StLatch} state_e;

    state_e             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic               edge_det;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        counter_q, counter_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic [CmpW-1:0]    count_ext, disp_max_ext;
    logic               over_max;

    assign edge_det     = s2_q & ~s3_q;
    assign count_ext    = CmpW'(count_q);
    assign disp_max_ext = CmpW'(DISP_MAX);
    assign over_max     = (count_ext > disp_max_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= StIdle;
            timer_q    <= '0;
            count_q    <= '0;
            counter_q  <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s1_q       <= sig_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            state_q    <= state_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            counter_q  <= counter_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        count_d    = count_q;
        counter_d  = counter_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                count_d = '0;
                if (enable) begin
                    state_d = StGate;
                end
            end
            StGate: begin
                if (!enable) begin
                    state_d = StIdle;
                    timer_d = '0;
                    count_d = '0;
                end else begin
                    if (edge_det && (count_q != '1)) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (timer_q == TimerLast) begin
                        state_d = StLatch;
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
            end
            StLatch: begin
                // Edges seen in this cycle are dropped: the count is cleared below.
                counter_d  = over_max ? disp_max_ext[31:0] : count_ext[31:0];
                overflow_d = over_max;
                valid_d    = 1'b1;
                timer_d    = '0;
                count_d    = '0;
                state_d    = enable ? StGate : StIdle;
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
                count_d = '0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    assign counter  = counter_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: table of single measurements plus sequences for
// continuous mode, abort, async reset, gate-boundary edges and display saturation.
`timescale 1ns/1ps
module tb_freq_gate_ctrl;

    typedef struct {
        int sel;
        int half;
        int n;
        int exp_cnt;
        int exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic man_sig = 1'b0;
    logic gen_sig = 1'b0;
    logic en_a = 1'b0, en_s = 1'b0, en_o = 1'b0;
    logic sig;
    int   gen_half = 0;
    int   gen_cnt = 0;
    int   checks = 0;
    int   failures = 0;
    int   tcount = 0;

    logic [31:0] cnt_a, cnt_s, cnt_o;
    logic        v_a, v_s, v_o, ov_a, ov_s, ov_o, b_a, b_s, b_o;

    assign sig = (gen_half != 0) ? gen_sig : man_sig;

    freq_gate_ctrl #(.GATE_CYCLES(100), .CNT_W(32), .DISP_MAX(9999)) dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig), .enable(en_a),
        .counter(cnt_a), .valid(v_a), .overflow(ov_a), .busy(b_a)
    );
    freq_gate_ctrl #(.GATE_CYCLES(100), .CNT_W(4), .DISP_MAX(9999)) dut_s (
        .clk(clk), .rst_n(rst_n), .sig_in(sig), .enable(en_s),
        .counter(cnt_s), .valid(v_s), .overflow(ov_s), .busy(b_s)
    );
    freq_gate_ctrl #(.GATE_CYCLES(30000), .CNT_W(32), .DISP_MAX(9999)) dut_o (
        .clk(clk), .rst_n(rst_n), .sig_in(sig), .enable(en_o),
        .counter(cnt_o), .valid(v_o), .overflow(ov_o), .busy(b_o)
    );

    always #5 clk = ~clk;

    // Free-running square wave source: toggles every gen_half cycles when non-zero.
    always begin
        @(posedge clk);
        #1;
        if (gen_half != 0) begin
            gen_cnt++;
            if (gen_cnt >= gen_half) begin
                gen_cnt = 0;
                gen_sig = ~gen_sig;
            end
        end else begin
            gen_cnt = 0;
            gen_sig = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tcount++;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo,
                           input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // {counter, valid, overflow, busy}
    function automatic logic [34:0] outs(input int sel);
        case (sel)
            0:       return {cnt_a, v_a, ov_a, b_a};
            1:       return {cnt_s, v_s, ov_s, b_s};
            default: return {cnt_o, v_o, ov_o, b_o};
        endcase
    endfunction

    task automatic set_en(input int sel, input logic v);
        case (sel)
            0:       en_a = v;
            1:       en_s = v;
            default: en_o = v;
        endcase
    endtask

    task automatic wait_valid(input int sel, input int max, output int n, output bit ok);
        logic [34:0] o;
        n  = 0;
        ok = 1'b0;
        while (n < max && !ok) begin
            tick();
            n++;
            o = outs(sel);
            if (o[2]) ok = 1'b1;
        end
    endtask

    task automatic run_meas(input vec_t v, input string name);
        int          t0, n;
        bit          ok;
        logic [34:0] o;
        man_sig = 1'b0;
        set_en(v.sel, 1'b1);
        t0 = tcount;
        tick();
        repeat (3) tick();
        for (int j = 0; j < v.n; j++) begin
            man_sig = 1'b1;
            repeat (v.half) tick();
            man_sig = 1'b0;
            repeat (v.half) tick();
        end
        wait_valid(v.sel, 200, n, ok);
        chk({name, "_valid_seen"}, ok, 1);
        if (ok) begin
            o = outs(v.sel);
            chk({name, "_latency"}, tcount - t0, 102);
            chk({name, "_counter"}, o[34:3], v.exp_cnt);
            chk({name, "_overflow"}, o[1], v.exp_ovf);
        end
        set_en(v.sel, 1'b0);
        repeat (4) tick();
    endtask

    // Rising edge applied k cycles into the gate; checks this result and the next one.
    task automatic edge_at(input int k, input int e1, input int e2, input string name);
        int n;
        bit ok;
        man_sig = 1'b0;
        en_a    = 1'b1;
        tick();
        repeat (k) tick();
        man_sig = 1'b1;
        wait_valid(0, 200, n, ok);
        chk({name, "_first_seen"}, ok, 1);
        chk({name, "_first_cnt"}, cnt_a, e1);
        wait_valid(0, 200, n, ok);
        chk({name, "_period"}, n, 101);
        chk({name, "_second_cnt"}, cnt_a, e2);
        en_a    = 1'b0;
        man_sig = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        vec_t vecs[6];
        int   n;
        bit   ok;
        bit   seen;

        vecs[0] = '{1, 2, 20, 15, 0};
        vecs[1] = '{0, 1, 0, 0, 0};
        vecs[2] = '{0, 1, 1, 1, 0};
        vecs[3] = '{0, 1, 40, 40, 0};
        vecs[4] = '{0, 2, 20, 20, 0};
        vecs[5] = '{0, 5, 9, 9, 0};

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_a", outs(0), 0);
        chk("reset_outs_o", outs(2), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            chk("idle_outs", outs(0), 0);
        end

        // Table of single measurements from IDLE
        for (int i = 0; i < 6; i++) begin
            run_meas(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort mid-gate: counter must keep 9 from the last vector
        en_a = 1'b1;
        tick();
        repeat (50) tick();
        chk("abort_busy_before", b_a, 1);
        en_a = 1'b0;
        tick();
        chk("abort_busy_drop", b_a, 0);
        chk("abort_counter_kept", cnt_a, 9);
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (v_a) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 0);
        run_meas('{0, 2, 7, 7, 0}, "reenable");

        // Continuous mode with a period-10 wave
        gen_half = 5;
        repeat (3) tick();
        en_a = 1'b1;
        tick();
        chk("nom_busy", b_a, 1);
        wait_valid(0, 200, n, ok);
        chk("nom_first_latency", n + 1, 102);
        chk_rng("nom_first_cnt", cnt_a, 9, 11);
        tick();
        chk("nom_valid_single", v_a, 0);
        wait_valid(0, 200, n, ok);
        chk("nom_period", n + 1, 101);
        chk_rng("nom_second_cnt", cnt_a, 9, 11);
        en_a = 1'b0;
        gen_half = 0;
        repeat (5) tick();

        // Async reset at timer=60
        en_a = 1'b1;
        tick();
        repeat (60) tick();
        rst_n = 1'b0;
        #0.5;
        chk("areset_outs_a", outs(0), 0);
        chk("areset_outs_s", outs(1), 0);
        #0.5;
        rst_n = 1'b1;
        wait_valid(0, 200, n, ok);
        chk("areset_fresh_latency", n, 102);
        chk("areset_fresh_cnt", cnt_a, 0);
        en_a = 1'b0;
        repeat (5) tick();

        // Gate boundary edges
        edge_at(97, 1, 0, "edge_final_gate");
        edge_at(98, 0, 0, "edge_latch");
        edge_at(99, 0, 1, "edge_next_gate");

        // Display saturation with a 30000-cycle gate
        gen_half = 1;
        en_o = 1'b1;
        repeat (29900) tick();
        gen_half = 5;
        wait_valid(2, 400, n, ok);
        chk("ovf_latency", n + 29900, 30002);
        chk("ovf_counter", cnt_o, 9999);
        chk("ovf_flag", ov_o, 1);
        wait_valid(2, 30100, n, ok);
        chk("ovf_period", n, 30001);
        chk_rng("ovf_recover_cnt", cnt_o, 2999, 3001);
        chk("ovf_recover_flag", ov_o, 0);
        en_o = 1'b0;
        gen_half = 0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
